// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes the predictor
// decodes, the fetch FSM state type and the branch counter reset value.
package inst_fetch_pkg;

  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;

  // Weakly not-taken: one taken outcome is enough to flip the prediction.
  localparam logic [1:0] BHT_RST_VAL = 2'b01;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Word-fetch bus between the fetch unit (master) and the memory
// controller (slave). A request is held until the completion pulse.
interface inst_fetch_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_done,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_done,
    output mem_data
  );

endinterface

// File: rtl/inst_fetch_bht.sv
// Branch history table: BHT_SIZE two-bit saturating counters with one
// combinational lookup port and one registered update port. Only built
// when BRANCH_PREDICT_EN is defined.
module bht
  import inst_fetch_pkg::*;
#(
  parameter int BHT_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rdy,
  input  logic [31:0] i_lk_pc,
  output logic [1:0]  o_lk_ctr,
  input  logic        i_upd_en,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken
);

  localparam int IDX_W = $clog2(BHT_SIZE);

  logic [1:0]       r_ctr [BHT_SIZE];
  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic             w_unused;

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
    if (taken)
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else
      return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

  assign w_lk_idx  = i_lk_pc[IDX_W+1:2];
  assign w_upd_idx = i_upd_pc[IDX_W+1:2];
  // Read of the registered array: a same-cycle update is not yet visible.
  assign o_lk_ctr  = r_ctr[w_lk_idx];
  assign w_unused  = ^{i_lk_pc[31:IDX_W+2], i_lk_pc[1:0],
                       i_upd_pc[31:IDX_W+2], i_upd_pc[1:0]};

  // Counter training from committed branches; reset to weakly not-taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BHT_SIZE; i++) r_ctr[i] <= BHT_RST_VAL;
    end else if (i_rdy && i_upd_en) begin
      r_ctr[w_upd_idx] <= sat_step(r_ctr[w_upd_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: direct-mapped one-word icache, two-state miss FSM and
// next-pc prediction (JAL always taken; conditional branches via the BHT).
// Optional feature macro: BRANCH_PREDICT_EN builds the BHT; without it
// conditional branches predict fall-through and br_* inputs are ignored.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int ICACHE_LINES = 16,
  parameter int BHT_SIZE     = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_rdy,
  input  logic               i_rs_full,
  input  logic               i_lsb_full,
  input  logic               i_rob_full,
  output logic               o_inst_rdy,
  output logic [31:0]        o_inst,
  output logic [31:0]        o_inst_pc,
  output logic               o_inst_pred_jump,
  inst_fetch_if.master       mem_if,
  input  logic               i_rollback,
  input  logic [31:0]        i_rollback_pc,
  input  logic               i_br_update,
  input  logic [31:0]        i_br_pc,
  input  logic               i_br_taken
);

  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 32 - IDX_W - 2;

  fetch_state_t          r_state;
  logic [31:0]           r_pc;
  logic                  r_inst_rdy;
  logic [31:0]           r_inst;
  logic [31:0]           r_inst_pc;
  logic                  r_pred_jump;
  logic                  r_mem_req;
  logic [31:0]           r_mem_addr;
  logic [ICACHE_LINES-1:0] r_ic_valid;
  logic [TAG_W-1:0]      r_ic_tag  [ICACHE_LINES];
  logic [31:0]           r_ic_data [ICACHE_LINES];

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic [31:0]           w_word;
  logic                  w_full;
  logic                  w_issue;
  logic                  w_fill;
  logic [IDX_W-1:0]      w_fill_idx;
  logic [TAG_W-1:0]      w_fill_tag;
  logic                  w_bht_taken;
  logic [31:0]           w_next_pc;
  logic                  w_pred;

  function automatic logic signed [31:0] imm_j(input logic [31:0] w);
    return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] w);
    return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  assign w_idx      = r_pc[IDX_W+1:2];
  assign w_tag      = r_pc[31:IDX_W+2];
  assign w_word     = r_ic_data[w_idx];
  assign w_hit      = r_ic_valid[w_idx] && (r_ic_tag[w_idx] == w_tag);
  assign w_full     = i_rs_full || i_lsb_full || i_rob_full;
  assign w_issue    = i_rdy && !i_rollback && !w_full && (r_state == S_IDLE) && w_hit;
  assign w_fill     = (r_state == S_WAIT_MEM) && mem_if.mem_done;
  assign w_fill_idx = r_mem_addr[IDX_W+1:2];
  assign w_fill_tag = r_mem_addr[31:IDX_W+2];

`ifdef BRANCH_PREDICT_EN
  logic [1:0] w_bht_ctr;

  bht #(
    .BHT_SIZE (BHT_SIZE)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .i_rdy       (i_rdy),
    .i_lk_pc     (r_pc),
    .o_lk_ctr    (w_bht_ctr),
    .i_upd_en    (i_br_update),
    .i_upd_pc    (i_br_pc),
    .i_upd_taken (i_br_taken)
  );

  assign w_bht_taken = w_bht_ctr[1];
`else
  logic w_unused;

  assign w_bht_taken = 1'b0;
  assign w_unused    = ^{i_br_update, i_br_pc, i_br_taken, 32'(BHT_SIZE)};
`endif

  // Next-pc prediction for the word currently addressed by pc.
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    w_pred    = 1'b0;
    if (w_word[6:0] == OPC_JAL) begin
      w_next_pc = r_pc + $unsigned(imm_j(w_word));
      w_pred    = 1'b1;
    end else if ((w_word[6:0] == OPC_BRANCH) && w_bht_taken) begin
      w_next_pc = r_pc + $unsigned(imm_b(w_word));
      w_pred    = 1'b1;
    end
  end

  // Fetch FSM, decoder outputs, memory request and icache valid bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pc        <= 32'd0;
      r_inst_rdy  <= 1'b0;
      r_inst      <= 32'd0;
      r_inst_pc   <= 32'd0;
      r_pred_jump <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_ic_valid  <= '0;
    end else if (i_rdy) begin
      r_inst_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_inst_rdy  <= 1'b1;
            r_inst      <= w_word;
            r_inst_pc   <= r_pc;
            r_pred_jump <= w_pred;
            r_pc        <= w_next_pc;
          end else if (!i_rollback && !w_hit) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= S_WAIT_MEM;
          end
        end
        S_WAIT_MEM: begin
          // The fill always completes, even across a rollback; the filled
          // word is issued later from IDLE as an ordinary hit.
          if (mem_if.mem_done) begin
            r_ic_valid[w_fill_idx] <= 1'b1;
            r_mem_req              <= 1'b0;
            r_state                <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (i_rollback) r_pc <= i_rollback_pc;
    end
  end

  // Icache data and tag capture on fill completion (no reset on data).
  always_ff @(posedge clk) begin
    if (rst && i_rdy && w_fill) begin
      r_ic_data[w_fill_idx] <= mem_if.mem_data;
      r_ic_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

  assign o_inst_rdy       = r_inst_rdy;
  assign o_inst           = r_inst;
  assign o_inst_pc        = r_inst_pc;
  assign o_inst_pred_jump = r_pred_jump;
  assign mem_if.mem_req   = r_mem_req;
  assign mem_if.mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a small memory responder serves fills,
// expected instructions are queued as each scenario is set up and checked
// on every inst_rdy pulse.
module tb_inst_fetch;

  localparam logic [31:0] W_NOP  = 32'h00000013;
  localparam logic [31:0] W_JAL  = 32'h008000EF;
  localparam logic [31:0] W_BR   = 32'hFE0008E3;
  localparam logic [31:0] W_ADDI = 32'h00100093;

`ifdef BRANCH_PREDICT_EN
  localparam logic        BR_PRED   = 1'b1;
  localparam logic [31:0] AFTER_PC  = 32'h10;
  localparam logic [31:0] AFTER_W   = W_JAL;
  localparam logic        AFTER_PRD = 1'b1;
`else
  localparam logic        BR_PRED   = 1'b0;
  localparam logic [31:0] AFTER_PC  = 32'h24;
  localparam logic [31:0] AFTER_W   = W_NOP;
  localparam logic        AFTER_PRD = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rs_full, lsb_full, rob_full;
  logic        inst_rdy;
  logic [31:0] inst, inst_pc;
  logic        pred_jump;
  logic        rollback;
  logic [31:0] rollback_pc;
  logic        br_update, br_taken;
  logic [31:0] br_pc;

  inst_fetch_if u_if ();

  inst_fetch #(
    .ICACHE_LINES (16),
    .BHT_SIZE     (256)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_rdy            (rdy),
    .i_rs_full        (rs_full),
    .i_lsb_full       (lsb_full),
    .i_rob_full       (rob_full),
    .o_inst_rdy       (inst_rdy),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .o_inst_pred_jump (pred_jump),
    .mem_if           (u_if.master),
    .i_rollback       (rollback),
    .i_rollback_pc    (rollback_pc),
    .i_br_update      (br_update),
    .i_br_pc          (br_pc),
    .i_br_taken       (br_taken)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  bit   mem_en = 1'b1;
  int   lat_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h10:  return W_JAL;
      32'h20:  return W_BR;
      32'h100: return W_ADDI;
      default: return W_NOP;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] w, input logic p);
    exp_t e;
    e.pc = pc; e.inst = w; e.pred = p;
    sb.push_back(e);
  endtask

  // One cycle: wait for the falling edge, score any delivered instruction,
  // then advance the memory responder (two-cycle latency, one-cycle done).
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (inst_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_inst_rdy", {31'b0, inst_rdy}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("inst_pc", inst_pc, e.pc);
        chk("inst", inst, e.inst);
        chk("pred_jump", {31'b0, pred_jump}, {31'b0, e.pred});
      end
    end
    if (u_if.mem_done) begin
      u_if.mem_done = 1'b0;
    end else if (u_if.mem_req === 1'b1 && mem_en) begin
      if (lat_cnt >= 1) begin
        u_if.mem_done = 1'b1;
        u_if.mem_data = mem_word(u_if.mem_addr);
        lat_cnt = 0;
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_req(input logic val, input string tag);
    int n = 0;
    while (u_if.mem_req !== val && n < 50) begin
      step();
      n++;
    end
    chk(tag, {31'b0, u_if.mem_req}, {31'b0, val});
  endtask

  task automatic chk_reset_outputs();
    chk("rst_inst_rdy", {31'b0, inst_rdy}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_pred_jump", {31'b0, pred_jump}, 32'd0);
    chk("rst_mem_req", {31'b0, u_if.mem_req}, 32'd0);
    chk("rst_mem_addr", u_if.mem_addr, 32'd0);
  endtask

  task automatic push_cold_stream();
    for (int a = 0; a < 16; a += 4) push(32'(a), W_NOP, 1'b0);
    push(32'h10, W_JAL, 1'b1);
    push(32'h18, W_NOP, 1'b0);
    push(32'h1C, W_NOP, 1'b0);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1;
    rs_full = 1'b0; lsb_full = 1'b0; rob_full = 1'b0;
    rollback = 1'b0; rollback_pc = 32'd0;
    br_update = 1'b0; br_pc = 32'd0; br_taken = 1'b0;
    u_if.mem_done = 1'b0; u_if.mem_data = 32'd0;

    // Reset state
    repeat (3) step();
    chk_reset_outputs();

    // Cold start, sequential fetch and the JAL at 0x10
    rst = 1'b1;
    step();
    chk("cold_mem_req", {31'b0, u_if.mem_req}, 32'd1);
    chk("cold_mem_addr", u_if.mem_addr, 32'd0);
    push_cold_stream();
    drain(300);

    // Five-cycle rob_full stall while training the branch at 0x20
    rob_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_update = (i < 3);
      br_pc     = 32'h20;
      br_taken  = 1'b1;
      step();
      chk("stall_inst_rdy", {31'b0, inst_rdy}, 32'd0);
    end
    br_update = 1'b0;
    rob_full  = 1'b0;
    push(32'h20, W_BR, BR_PRED);
    push(AFTER_PC, AFTER_W, AFTER_PRD);
    drain(100);

    // Rollback while a fill is outstanding
    mem_en = 1'b0;
    rollback = 1'b1; rollback_pc = 32'h200;
    step();
    rollback = 1'b0;
    step();
    chk("miss_mem_req", {31'b0, u_if.mem_req}, 32'd1);
    chk("miss_mem_addr", u_if.mem_addr, 32'h200);
    rollback = 1'b1; rollback_pc = 32'h100;
    step();
    rollback = 1'b0;
    chk("req_held_on_rollback", {31'b0, u_if.mem_req}, 32'd1);
    mem_en = 1'b1;
    wait_req(1'b0, "fill_completes");
    wait_req(1'b1, "refetch_req");
    chk("refetch_addr", u_if.mem_addr, 32'h100);
    push(32'h100, W_ADDI, 1'b0);
    drain(100);

    // Reset in the middle of a fill, with stray completion pulses
    mem_en = 1'b0;
    wait_req(1'b1, "midfill_req");
    chk("midfill_addr", u_if.mem_addr, 32'h104);
    rst = 1'b0;
    u_if.mem_done = 1'b1; u_if.mem_data = 32'hDEADBEEF;
    step();
    step();
    chk_reset_outputs();
    rst = 1'b1;
    u_if.mem_done = 1'b1; u_if.mem_data = 32'hDEADBEEF;
    mem_en = 1'b1;
    step();
    chk("restart_mem_req", {31'b0, u_if.mem_req}, 32'd1);
    chk("restart_mem_addr", u_if.mem_addr, 32'd0);
    push_cold_stream();
    push(32'h20, W_BR, 1'b0);
    push(32'h24, W_NOP, 1'b0);
    drain(300);

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
